// File: rtl/rtc_bus_write_sequencer.sv
// Runs one RTC write on the muxed AD bus: address phase, CS-high gap, data phase.
// 28 busy cycles at default timing; wr_req is ignored, never queued, while busy.
module rtc_bus_write_sequencer #(
    parameter int DW      = 8,
    parameter int T_SETUP = 1,
    parameter int T_WR    = 6,
    parameter int T_HOLD  = 1,
    parameter int T_GAP   = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_req,
    input  logic [DW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          busy,
    output logic          wr_done,
    output logic          cs,
    output logic          rd,
    output logic          wr,
    output logic          a_d,
    output logic [DW-1:0] ad_out,
    output logic          ad_oe
);

    localparam int MAX_A = (T_SETUP > T_WR) ? T_SETUP : T_WR;
    localparam int MAX_B = (T_HOLD > T_GAP) ? T_HOLD : T_GAP;
    localparam int MAXP  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TW    = $clog2(MAXP + 1);

    typedef enum logic [3:0] {
        IDLE, A_PRE, A_CS, A_WR, A_HOLD, GAP, D_CS, D_WR, D_HOLD, DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [TW-1:0]   timer;
    logic            advance;
    logic            accept;
    logic [DW-1:0]   addr_q;
    logic [DW-1:0]   data_q;
    logic [DW-1:0]   addr_src;

    logic            busy_nxt;
    logic            done_nxt;
    logic            cs_nxt;
    logic            wr_nxt;
    logic            a_d_nxt;
    logic            oe_nxt;
    logic [DW-1:0]   ad_nxt;

    // Timer reload value: state duration minus one, so the last cycle sees zero.
    function automatic logic [TW-1:0] dur_m1(input state_t s);
        case (s)
            A_CS, D_CS:     dur_m1 = TW'(T_SETUP - 1);
            A_WR, D_WR:     dur_m1 = TW'(T_WR - 1);
            A_HOLD, D_HOLD: dur_m1 = TW'(T_HOLD - 1);
            GAP:            dur_m1 = TW'(T_GAP - 1);
            default:        dur_m1 = '0;
        endcase
    endfunction

    assign accept = (state == IDLE) && wr_req;
    // The address is not yet latched on the accept edge, so A_PRE takes it from the input.
    assign addr_src = accept ? wr_addr : addr_q;
    assign rd = 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            timer   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            busy    <= 1'b0;
            wr_done <= 1'b0;
            cs      <= 1'b1;
            wr      <= 1'b1;
            a_d     <= 1'b1;
            ad_oe   <= 1'b0;
            ad_out  <= '0;
        end else begin
            state <= state_nxt;
            if (advance) begin
                timer <= dur_m1(state_nxt);
            end else if (timer != '0) begin
                timer <= timer - TW'(1);
            end
            if (accept) begin
                addr_q <= wr_addr;
                data_q <= wr_data;
            end
            busy    <= busy_nxt;
            wr_done <= done_nxt;
            cs      <= cs_nxt;
            wr      <= wr_nxt;
            a_d     <= a_d_nxt;
            ad_oe   <= oe_nxt;
            ad_out  <= ad_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        advance   = 1'b0;
        if (state == IDLE) begin
            if (wr_req) begin
                state_nxt = A_PRE;
                advance   = 1'b1;
            end
        end else if (timer == '0) begin
            advance = 1'b1;
            case (state)
                A_PRE:   state_nxt = A_CS;
                A_CS:    state_nxt = A_WR;
                A_WR:    state_nxt = A_HOLD;
                A_HOLD:  state_nxt = GAP;
                GAP:     state_nxt = D_CS;
                D_CS:    state_nxt = D_WR;
                D_WR:    state_nxt = D_HOLD;
                D_HOLD:  state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so they line up with the state.
    always_comb begin
        busy_nxt = (state_nxt != IDLE);
        done_nxt = 1'b0;
        cs_nxt   = 1'b1;
        wr_nxt   = 1'b1;
        a_d_nxt  = 1'b1;
        oe_nxt   = 1'b0;
        ad_nxt   = '0;
        case (state_nxt)
            A_PRE: begin
                a_d_nxt = 1'b0;
                ad_nxt  = addr_src;
            end
            A_CS, A_HOLD: begin
                cs_nxt  = 1'b0;
                a_d_nxt = 1'b0;
                oe_nxt  = 1'b1;
                ad_nxt  = addr_src;
            end
            A_WR: begin
                cs_nxt  = 1'b0;
                wr_nxt  = 1'b0;
                a_d_nxt = 1'b0;
                oe_nxt  = 1'b1;
                ad_nxt  = addr_src;
            end
            D_CS, D_HOLD: begin
                cs_nxt = 1'b0;
                oe_nxt = 1'b1;
                ad_nxt = data_q;
            end
            D_WR: begin
                cs_nxt = 1'b0;
                wr_nxt = 1'b0;
                oe_nxt = 1'b1;
                ad_nxt = data_q;
            end
            DONE:    done_nxt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rtc_bus_write_sequencer.sv
// Directed bench: timeline model per cycle, wr-window scoreboard keyed on wr_done, bus invariants.
module tb_rtc_bus_write_sequencer;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          rst, wr_req, busy, wr_done, cs, rd, wr, a_d, ad_oe;
    logic [DW-1:0] wr_addr, wr_data, ad_out;
    logic          r5_rst, r5_req, r5_busy, r5_done, r5_cs, r5_rd, r5_wr, r5_a_d, r5_oe;
    logic [DW-1:0] r5_addr, r5_data, r5_ad;

    rtc_bus_write_sequencer dut (
        .clk(clk), .rst(rst), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .wr_done(wr_done), .cs(cs), .rd(rd), .wr(wr), .a_d(a_d),
        .ad_out(ad_out), .ad_oe(ad_oe)
    );

    rtc_bus_write_sequencer #(.DW(8), .T_SETUP(2), .T_WR(3), .T_HOLD(2), .T_GAP(1)) dut5 (
        .clk(clk), .rst(r5_rst), .wr_req(r5_req), .wr_addr(r5_addr), .wr_data(r5_data),
        .busy(r5_busy), .wr_done(r5_done), .cs(r5_cs), .rd(r5_rd), .wr(r5_wr), .a_d(r5_a_d),
        .ad_out(r5_ad), .ad_oe(r5_oe)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
        end
    endtask

    // Expected {cs, wr, a_d, oe, done, src[1:0]} for the outputs 'off' edges after accept.
    // src: 0 = ad_out zero, 1 = address, 2 = data, 3 = not checked.
    function automatic logic [6:0] model(input int off, input int ts, input int tw,
                                         input int th, input int tg);
        int         dur [9];
        logic [6:0] val [9];
        int         base;
        dur = '{1, ts, tw, th, tg, ts, tw, th, 1};
        val = '{7'b1100011, 7'b0101001, 7'b0001001, 7'b0101001, 7'b1110000,
                7'b0111010, 7'b0011010, 7'b0111010, 7'b1110100};
        base = 0;
        model = 7'b1110000;
        for (int i = 0; i < 9; i++) begin
            if (off >= base && off < base + dur[i]) model = val[i];
            base += dur[i];
        end
    endfunction

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        int         done_cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t sb_e;
    int   win_n = 0;
    int   win_w = 0;
    int   done_seen = 0;
    logic prev_wr = 1'b1, prev_a_d = 1'b1, prev_done = 1'b0;
    logic p5_a_d = 1'b1, p5_done = 1'b0;

    task automatic inv(input string tag, input logic c, input logic w, input logic ad,
                       input logic oe, input logic r, input logic pad);
        chk({tag, "_rd_high"}, r, 1'b1);
        chk({tag, "_oe_needs_cs_low"}, oe & c, 1'b0);
        chk({tag, "_wr_low_needs_cs_low"}, ~w & c, 1'b0);
        if (ad !== pad) chk({tag, "_a_d_change_cs_high"}, c, 1'b1);
    endtask

    // Scoreboard: wr-low windows compared against the pending transaction, popped on wr_done.
    always @(negedge clk) begin
        inv("dut", cs, wr, a_d, ad_oe, rd, prev_a_d);
        inv("dut5", r5_cs, r5_wr, r5_a_d, r5_oe, r5_rd, p5_a_d);
        if (r5_done) chk("dut5_done_single", p5_done, 1'b0);
        if (!busy) begin
            win_n = 0;
            win_w = 0;
        end
        if (!wr) begin
            win_w++;
            chk("win_txn_pending", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                chk("win_a_d", a_d, win_n == 1);
                chk("win_ad_out", ad_out, (win_n == 0) ? exp_q[0].addr : exp_q[0].data);
            end
        end else if (!prev_wr) begin
            chk("wr_low_width", win_w, 6);
            win_w = 0;
            win_n++;
        end
        if (wr_done) begin
            chk("done_single", prev_done, 1'b0);
            chk("done_txn_pending", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                sb_e = exp_q.pop_front();
                chk("done_edge", cyc, sb_e.done_cyc);
                chk("done_windows", win_n, 2);
                done_seen++;
            end
        end
        prev_wr   = wr;
        prev_a_d  = a_d;
        prev_done = wr_done;
        p5_a_d    = r5_a_d;
        p5_done   = r5_done;
    end

    task automatic watch(input string tag, input int e0, input int n,
                         input logic [7:0] ea, input logic [7:0] ed);
        logic [6:0] m;
        int off;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            off = cyc - e0;
            m = model(off, 1, 6, 1, 10);
            chk({tag, "_strobes"}, {cs, wr, a_d, ad_oe, wr_done}, m[6:2]);
            chk({tag, "_busy"}, busy, (off >= 0 && off < 28));
            case (m[1:0])
                2'b00:   chk({tag, "_ad_zero"}, ad_out, 8'h00);
                2'b01:   chk({tag, "_ad_addr"}, ad_out, ea);
                2'b10:   chk({tag, "_ad_data"}, ad_out, ed);
                default: ;
            endcase
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int e0, e1, done_off, run, first_lo, last_lo, gap;
        logic [6:0] m;
        logic w5h [20];
        logic c5h [20];
        int runs[$];

        rst = 1'b1; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        r5_rst = 1'b1; r5_req = 1'b0; r5_addr = '0; r5_data = '0;
        repeat (3) step();
        @(negedge clk);
        chk("reset_outs", {busy, wr_done, cs, rd, wr, a_d, ad_oe}, 7'b0011110);
        chk("reset_ad_out", ad_out, 8'h00);
        chk("reset5_outs", {r5_busy, r5_done, r5_cs, r5_rd, r5_wr, r5_a_d, r5_oe}, 7'b0011110);
        step();
        rst = 1'b0; r5_rst = 1'b0;

        // Single write.
        step();
        wr_req = 1'b1; wr_addr = 8'h21; wr_data = 8'h45;
        e0 = cyc + 1;
        exp_q.push_back('{8'h21, 8'h45, e0 + 27});
        step();
        wr_req = 1'b0;
        watch("t1", e0, 30, 8'h21, 8'h45);

        // wr_req held high: accepts at E0 and E29 only.
        step();
        wr_req = 1'b1;
        e0 = cyc + 1;
        exp_q.push_back('{8'h21, 8'h45, e0 + 27});
        exp_q.push_back('{8'h21, 8'h45, e0 + 29 + 27});
        step();
        watch("t2a", e0, 28, 8'h21, 8'h45);
        watch("t2b", e0 + 29, 29, 8'h21, 8'h45);
        wr_req = 1'b0;

        // Inputs change mid-transfer; the latched values must stay on the bus.
        step();
        step();
        wr_req = 1'b1; wr_addr = 8'h21; wr_data = 8'h45;
        e0 = cyc + 1;
        exp_q.push_back('{8'h21, 8'h45, e0 + 27});
        step();
        wr_req = 1'b0;
        watch("t3a", e0, 6, 8'h21, 8'h45);
        wr_addr = 8'hFF; wr_data = 8'hFF;
        watch("t3b", e0, 24, 8'h21, 8'h45);

        // Reset in GAP aborts without wr_done; next request accepted normally.
        step();
        wr_req = 1'b1; wr_addr = 8'h33; wr_data = 8'h5A;
        e0 = cyc + 1;
        exp_q.push_back('{8'h33, 8'h5A, e0 + 27});
        step();
        wr_req = 1'b0;
        watch("t4a", e0, 11, 8'h33, 8'h5A);
        step();
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("t4_gap_busy", busy, 1'b1);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t4_reset_outs", {busy, wr_done, cs, rd, wr, a_d, ad_oe}, 7'b0011110);
        chk("t4_reset_ad_out", ad_out, 8'h00);
        step();
        wr_req = 1'b1; wr_addr = 8'h21; wr_data = 8'h45;
        e1 = cyc + 1;
        exp_q.push_back('{8'h21, 8'h45, e1 + 27});
        step();
        wr_req = 1'b0;
        watch("t4b", e1, 30, 8'h21, 8'h45);

        // Non-default timing instance.
        step();
        r5_req = 1'b1; r5_addr = 8'h5A; r5_data = 8'hC3;
        e0 = cyc + 1;
        step();
        r5_req = 1'b0;
        done_off = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            m = model(cyc - e0, 2, 3, 2, 1);
            chk("t5_strobes", {r5_cs, r5_wr, r5_a_d, r5_oe, r5_done}, m[6:2]);
            chk("t5_busy", r5_busy, (cyc - e0) < 17);
            if (m[1:0] == 2'b01) chk("t5_ad_addr", r5_ad, 8'h5A);
            if (m[1:0] == 2'b10) chk("t5_ad_data", r5_ad, 8'hC3);
            w5h[k] = r5_wr;
            c5h[k] = r5_cs;
            if (r5_done) done_off = cyc - e0;
        end
        run = 0;
        first_lo = -1;
        last_lo = -1;
        for (int k = 0; k < 20; k++) begin
            if (!w5h[k]) run++;
            else if (run > 0) begin
                runs.push_back(run);
                run = 0;
            end
            if (!c5h[k]) begin
                if (first_lo < 0) first_lo = k;
                last_lo = k;
            end
        end
        gap = 0;
        for (int k = 0; k < 20; k++)
            if (k > first_lo && k < last_lo && c5h[k]) gap++;
        chk("t5_wr_runs", runs.size(), 2);
        foreach (runs[i]) chk("t5_wr_width", runs[i], 3);
        chk("t5_gap_width", gap, 1);
        chk("t5_done_edge", done_off, 16);

        repeat (3) step();
        chk("sb_empty", exp_q.size(), 0);
        chk("done_count", done_seen, 5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
